// File: rtl/ber_checker.sv
// ber_checker: bit-error-rate checker behind the 4-tap FIR in the TP2 link chain.
//
// Decimates the oversampled filter output at a selectable phase and slices each kept sample
// by sign. It then searches candidate delays against the transmitted PRBS reference. A delay
// locks once a whole search window compares clean. After lock, saturating bit and error
// counters accumulate.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous, active-high reset (priority over every other input)
//   i_en         sample valid, one FIR output sample per asserted cycle
//   i_data       signed filtered sample, S(NB_DATA,15)
//   i_ref_bit    transmitted PRBS bit, valid on symbol strobes
//   i_phase      sampling phase within the symbol
//   i_clear      zero both counters without dropping lock
//   o_locked     alignment found
//   o_delay      candidate delay being tried, or the locked delay
//   o_bit_count  symbols compared while locked (saturating)
//   o_err_count  mismatches while locked (saturating, frozen once o_bit_count saturates)
module ber_checker #(
  parameter int unsigned NB_DATA    = 18,
  parameter int unsigned OS         = 4,
  parameter int unsigned MAX_DELAY  = 64,
  parameter int unsigned SEARCH_LEN = 128,
  parameter int unsigned NB_CNT     = 32,
  localparam int unsigned NbPh      = (OS > 1) ? $clog2(OS) : 1,
  localparam int unsigned NbDly     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic signed [NB_DATA-1:0] i_data,
  input  logic                      i_ref_bit,
  input  logic [NbPh-1:0]           i_phase,
  input  logic                      i_clear,
  output logic                      o_locked,
  output logic [NbDly-1:0]          o_delay,
  output logic [NB_CNT-1:0]         o_bit_count,
  output logic [NB_CNT-1:0]         o_err_count
);

  localparam int unsigned NbWin = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;
  localparam logic [NB_CNT-1:0] CntMax = '1;

  typedef enum logic [0:0] {
    StSearch,
    StLocked
  } state_e;

  state_e               state_q, state_d;
  logic [NbPh-1:0]      phase_q, phase_d;
  logic [NbWin-1:0]     win_cnt_q, win_cnt_d;
  logic [NbWin:0]       win_err_q, win_err_d;
  logic [MAX_DELAY-1:0] ref_sr_q, ref_sr_d;
  logic [NbDly-1:0]     delay_q, delay_d;
  logic [NB_CNT-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]    err_cnt_q, err_cnt_d;

  logic strb;
  logic dec_bit;
  logic err;
  logic win_last;
  logic win_clean;

  // Symbol strobe and slicer. The comparison uses ref_sr before this edge's shift, so
  // delay 0 pairs the current sample with the reference bit of the previous strobe.
  always_comb begin
    strb      = i_en && (phase_q == i_phase);
    dec_bit   = i_data[NB_DATA-1];
    err       = dec_bit ^ ref_sr_q[delay_q];
    win_last  = (win_cnt_q == NbWin'(SEARCH_LEN - 1));
    // Window verdict includes the final strobe's own error.
    win_clean = (win_err_q == '0) && !err;
  end

  // Phase counter and reference shift register.
  always_comb begin
    phase_d  = phase_q;
    ref_sr_d = ref_sr_q;
    if (i_en) begin
      phase_d = (phase_q == NbPh'(OS - 1)) ? '0 : phase_q + NbPh'(1);
    end
    if (strb) begin
      ref_sr_d = {ref_sr_q[MAX_DELAY-2:0], i_ref_bit};
    end
  end

  // Search / lock FSM and counters.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    delay_d   = delay_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      StSearch: begin
        if (strb) begin
          if (win_last) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_clean) begin
              state_d = StLocked;
            end else begin
              // MAX_DELAY is a power of two, so natural overflow wraps the last delay to 0.
              delay_d = delay_q + NbDly'(1);
            end
          end else begin
            win_cnt_d = win_cnt_q + NbWin'(1);
            win_err_d = win_err_q + {{NbWin{1'b0}}, err};
          end
        end
      end
      StLocked: begin
        // The error counter stops together with the bit counter so the ratio stays meaningful.
        if (strb && (bit_cnt_q != CntMax)) begin
          bit_cnt_d = bit_cnt_q + NB_CNT'(1);
          if (err && (err_cnt_q != CntMax)) begin
            err_cnt_d = err_cnt_q + NB_CNT'(1);
          end
        end
      end
      default: begin
        state_d = StSearch;
      end
    endcase

    // Clear beats a coincident strobe.
    if (i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StSearch;
      phase_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      ref_sr_q  <= '0;
      delay_q   <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      ref_sr_q  <= ref_sr_d;
      delay_q   <= delay_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_locked    = (state_q == StLocked);
  assign o_delay     = delay_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker. Two instances share every input: one with 32-bit counters
// and one with 4-bit counters to exercise saturation and the error-counter freeze.
module tb_ber_checker;

  localparam int unsigned NbData = 18;
  localparam int unsigned Os     = 4;
  localparam int unsigned SLen   = 128;
  localparam logic signed [NbData-1:0] Pos = 18'sd8192;
  localparam logic signed [NbData-1:0] Neg = -18'sd8192;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic signed [NbData-1:0] data;
  logic                     ref_bit;
  logic [1:0]               phase_sel;
  logic                     clear;

  logic        locked_l, locked_s;
  logic [5:0]  delay_l, delay_s;
  logic [31:0] bits_l, errs_l;
  logic [3:0]  bits_s, errs_s;

  always #5 clk = ~clk;

  ber_checker #(
    .NB_DATA(NbData), .OS(Os), .MAX_DELAY(64), .SEARCH_LEN(SLen), .NB_CNT(32)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_ref_bit(ref_bit),
    .i_phase(phase_sel), .i_clear(clear), .o_locked(locked_l), .o_delay(delay_l),
    .o_bit_count(bits_l), .o_err_count(errs_l)
  );

  ber_checker #(
    .NB_DATA(NbData), .OS(Os), .MAX_DELAY(64), .SEARCH_LEN(SLen), .NB_CNT(4)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data), .i_ref_bit(ref_bit),
    .i_phase(phase_sel), .i_clear(clear), .o_locked(locked_s), .o_delay(delay_s),
    .o_bit_count(bits_s), .o_err_count(errs_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus model: PRBS9 reference (x^9 + x^5 + 1), history of sent bits, and the sliced
  // data stream built from that history with a chosen alignment delay.
  logic [8:0] lfsr;
  bit         hist [0:16383];
  int         k;          // symbol index since last reset
  int         dly;        // data bit at symbol k = reference bit of symbol k-1-dly
  int         valid_ph;   // phase carrying the true sample; others carry its inverse

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; data = Neg; ref_bit = 1'b1; clear = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    k = 0;
    lfsr = 9'h1FF;
  endtask

  // One symbol = Os cycles with i_en high; the reference bit is held for the whole symbol.
  task automatic symbol(input bit inv, input bit clr);
    bit rb;
    bit db;
    rb = lfsr[8];
    hist[k] = rb;
    db = (k >= dly + 1) ? hist[k-dly-1] : 1'b0;
    db = db ^ inv;
    lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    for (int p = 0; p < int'(Os); p++) begin
      en      = 1'b1;
      ref_bit = rb;
      if (p == valid_ph) data = db ? Neg : Pos;
      else               data = db ? Pos : Neg;
      clear   = clr && (p == int'(phase_sel));
      @(posedge clk); #1;
    end
    clear = 1'b0;
    en    = 1'b0;
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) symbol(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data = '0; ref_bit = 1'b0; phase_sel = 2'd0; clear = 1'b0;
    dly = 0; valid_ph = 0;
    do_reset();

    // Reset state
    chk("rst_locked", locked_l, 0);
    chk("rst_delay", delay_l, 0);
    chk("rst_bits", bits_l, 0);
    chk("rst_errs", errs_l, 0);
    chk("rst_bits_s", bits_s, 0);

    // Delayed match: alignment at delay 5 locks on strobe 6*128
    dly = 5; valid_ph = 0; phase_sel = 2'd0;
    run(SLen);
    chk("a_delay_after_win0", delay_l, 1);
    chk("a_unlocked_win0", locked_l, 0);
    chk("a_bits_search", bits_l, 0);
    run(6 * SLen - 1 - SLen);
    chk("a_unlocked_before", locked_l, 0);
    chk("a_delay_before", delay_l, 5);
    symbol(1'b0, 1'b0);
    chk("a_locked", locked_l, 1);
    chk("a_delay_locked", delay_l, 5);
    chk("a_bits_at_lock", bits_l, 0);

    // Error injection: 3 inverted symbols out of 1000
    for (int i = 0; i < 1000; i++) symbol(i == 10 || i == 500 || i == 999, 1'b0);
    chk("b_bits", bits_l, 1000);
    chk("b_errs", errs_l, 3);
    chk("b_bits_sat", bits_s, 15);
    chk("b_errs_frozen", errs_s, 1);
    chk("b_still_locked", locked_l, 1);

    // Clear coinciding with an erroneous strobe: clear wins
    symbol(1'b1, 1'b1);
    chk("c_bits_clr", bits_l, 0);
    chk("c_errs_clr", errs_l, 0);
    chk("c_bits_s_clr", bits_s, 0);
    chk("c_errs_s_clr", errs_s, 0);
    chk("c_locked_clr", locked_l, 1);
    run(20);
    chk("c_bits_20", bits_l, 20);
    chk("c_bits_s_sat", bits_s, 15);
    chk("c_errs_20", errs_l, 0);

    // Mid-lock reset
    do_reset();
    chk("d_locked", locked_l, 0);
    chk("d_delay", delay_l, 0);
    chk("d_bits", bits_l, 0);
    chk("d_errs", errs_l, 0);
    chk("d_bits_s", bits_s, 0);

    // Phase select: true data only at phase 2
    dly = 3; valid_ph = 2; phase_sel = 2'd2;
    run(SLen);
    chk("e_restart_delay1", delay_l, 1);
    run(3 * SLen);
    chk("e_locked", locked_l, 1);
    chk("e_delay", delay_l, 3);
    run(50);
    chk("e_bits_50", bits_l, 50);
    chk("e_errs_0", errs_l, 0);
    phase_sel = 2'd0;
    run(20);
    chk("e_bits_70", bits_l, 70);
    chk("e_errs_20", errs_l, 20);
    chk("e_locked_kept", locked_l, 1);
    chk("e_errs_s_frozen", errs_s, 0);

    // Wrap and no-lock: alignment beyond the search range
    do_reset();
    dly = 70; valid_ph = 0; phase_sel = 2'd0;
    run(63 * SLen);
    chk("f_delay_63", delay_l, 63);
    chk("f_unlocked_63", locked_l, 0);
    run(SLen);
    chk("f_delay_wrap", delay_l, 0);
    chk("f_unlocked_wrap", locked_l, 0);
    chk("f_bits_search", bits_l, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
